// File: rtl/cpu_pkg.sv
// Shared definitions for the picoMIPS fetch/decode controller: instruction layout,
// opcodes and sequencer states.
package cpu_pkg;

   localparam int I_WIDTH = 12;

   localparam int OPC_MSB = 11;
   localparam int OPC_LSB = 6;
   localparam int IMM_MSB = 5;
   localparam int IMM_LSB = 3;
   localparam int OFS_MSB = 2;
   localparam int OFS_LSB = 0;

   localparam int OPC_W = OPC_MSB - OPC_LSB + 1;
   localparam int IMM_W = IMM_MSB - IMM_LSB + 1;
   localparam int OFS_W = OFS_MSB - OFS_LSB + 1;

   localparam logic [OPC_W-1:0] OP_NOP = 6'b000000;
   localparam logic [OPC_W-1:0] OP_MUL = 6'b000001;
   localparam logic [OPC_W-1:0] OP_ADD = 6'b000010;
   localparam logic [OPC_W-1:0] OP_END = 6'b000011;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE,
      ERR
   } seq_state_t;

endpackage

// File: rtl/instr_decode.sv
// Combinational decode of one picoMIPS instruction word into opcode class flags
// and the coefficient-select / sample-offset fields.
module instr_decode
   import cpu_pkg::*;
(
   input  logic [I_WIDTH-1:0] instruction,
   output logic               is_mul,
   output logic               is_add,
   output logic               is_end,
   output logic               is_illegal,
   output logic [IMM_W-1:0]   coef,
   output logic [OFS_W-1:0]   ofs
);

   logic [OPC_W-1:0] opc;

   always_comb begin
      opc        = instruction[OPC_MSB:OPC_LSB];
      coef       = instruction[IMM_MSB:IMM_LSB];
      ofs        = instruction[OFS_MSB:OFS_LSB];
      is_mul     = (opc == OP_MUL);
      is_add     = (opc == OP_ADD);
      is_end     = (opc == OP_END);
      is_illegal = !((opc == OP_NOP) || is_mul || is_add || is_end);
   end

endmodule

// File: rtl/instr_sequencer.sv
// Fetch/decode controller running a picoMIPS program from address 0 until END.
// Build option ILLEGAL_OP_TRAP_EN: illegal opcodes trap to ERR instead of acting as NOP.
module instr_sequencer
   import cpu_pkg::*;
#(
   parameter int ADDR_WIDTH  = 6,
   parameter int DADDR_WIDTH = 8
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          start,
   input  logic                          stall,
   input  logic [I_WIDTH-1:0]            instruction,
   output logic [ADDR_WIDTH-1:0]         pc,
   output logic                          busy,
   output logic                          mul_en,
   output logic                          add_en,
   output logic [IMM_W-1:0]              coef_sel,
   output logic signed [DADDR_WIDTH-1:0] offset_ext,
   output logic                          done,
   output logic                          err
);

`ifdef ILLEGAL_OP_TRAP_EN
   localparam bit TRAP_EN = 1'b1;
`else
   localparam bit TRAP_EN = 1'b0;
`endif

   localparam logic [ADDR_WIDTH-1:0] PC_LAST = '1;

   function automatic logic signed [DADDR_WIDTH-1:0] sext_ofs(input logic [OFS_W-1:0] f);
      return {{(DADDR_WIDTH-OFS_W){f[OFS_W-1]}}, f};
   endfunction

   seq_state_t                    state, state_nxt;
   logic [ADDR_WIDTH-1:0]         pc_nxt;
   logic                          mul_nxt, add_nxt, done_nxt, err_nxt;
   logic [IMM_W-1:0]              coef_nxt;
   logic signed [DADDR_WIDTH-1:0] ofs_nxt;

   logic             is_mul, is_add, is_end, is_illegal;
   logic [IMM_W-1:0] dec_coef;
   logic [OFS_W-1:0] dec_ofs;

   instr_decode u_decode (
      .instruction (instruction),
      .is_mul      (is_mul),
      .is_add      (is_add),
      .is_end      (is_end),
      .is_illegal  (is_illegal),
      .coef        (dec_coef),
      .ofs         (dec_ofs)
   );

   assign busy = (state == RUN);

   always_comb begin
      state_nxt = state;
      pc_nxt    = pc;
      mul_nxt   = 1'b0;
      add_nxt   = 1'b0;
      done_nxt  = 1'b0;
      err_nxt   = err;
      coef_nxt  = coef_sel;
      ofs_nxt   = offset_ext;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = RUN;
               pc_nxt    = '0;
               err_nxt   = 1'b0;
            end
         end
         RUN: begin
            // A stalled cycle issues nothing and keeps pc, so the word is re-decoded.
            if (!stall) begin
               if (is_end) begin
                  state_nxt = DONE;
                  done_nxt  = 1'b1;
               end else if (TRAP_EN && is_illegal) begin
                  state_nxt = ERR;
                  err_nxt   = 1'b1;
               end else begin
                  mul_nxt = is_mul;
                  add_nxt = is_add;
                  if (is_mul) begin
                     coef_nxt = dec_coef;
                     ofs_nxt  = sext_ofs(dec_ofs);
                  end
                  // Running off the top of program memory is a fault; pc never wraps.
                  if (pc == PC_LAST) begin
                     state_nxt = ERR;
                     err_nxt   = 1'b1;
                  end else begin
                     pc_nxt = pc + ADDR_WIDTH'(1);
                  end
               end
            end
         end
         DONE: state_nxt = IDLE;
         ERR:  state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         pc         <= '0;
         mul_en     <= 1'b0;
         add_en     <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
         coef_sel   <= '0;
         offset_ext <= '0;
      end else begin
         state      <= state_nxt;
         pc         <= pc_nxt;
         mul_en     <= mul_nxt;
         add_en     <= add_nxt;
         done       <= done_nxt;
         err        <= err_nxt;
         coef_sel   <= coef_nxt;
         offset_ext <= ofs_nxt;
      end
   end

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: program memory model, program-walking reference trace,
// directed timing scenarios and randomized programs.
module tb_instr_sequencer;
   import cpu_pkg::*;

   localparam int AW   = 6;
   localparam int DW   = 8;
   localparam int MEMN = 64;
   localparam int NC   = 160;

`ifdef ILLEGAL_OP_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   logic                 clk = 1'b0;
   logic                 reset, start, stall;
   logic [I_WIDTH-1:0]   instruction;
   logic [AW-1:0]        pc;
   logic                 busy, mul_en, add_en, done, err;
   logic [2:0]           coef_sel;
   logic signed [DW-1:0] offset_ext;

   logic [11:0] mem [MEMN];
   assign instruction = mem[pc];

   always #5 clk = ~clk;

   instr_sequencer #(.ADDR_WIDTH(AW), .DADDR_WIDTH(DW)) dut (
      .clk(clk), .reset(reset), .start(start), .stall(stall),
      .instruction(instruction), .pc(pc), .busy(busy), .mul_en(mul_en),
      .add_en(add_en), .coef_sel(coef_sel), .offset_ext(offset_ext),
      .done(done), .err(err)
   );

   int nassert = 0;
   int nfail   = 0;

   bit start_v [NC];
   bit stall_v [NC];
   int e_pc [NC], e_coef [NC], e_ofs [NC];
   bit e_busy [NC], e_mul [NC], e_add [NC], e_done [NC], e_err [NC];
   int o_pc [NC], o_coef [NC], o_ofs [NC];
   int o_busy [NC], o_mul [NC], o_add [NC], o_done [NC], o_err [NC];
   int cur_coef, cur_ofs;

   function automatic logic [11:0] w_nop();
      return 12'h000;
   endfunction
   function automatic logic [11:0] w_mul(input int c, input int o);
      logic [2:0] cc, oo;
      cc = 3'(c);
      oo = 3'(o);
      return {6'd1, cc, oo};
   endfunction
   function automatic logic [11:0] w_add();
      return {6'd2, 6'd0};
   endfunction
   function automatic logic [11:0] w_end();
      return {6'd3, 6'd0};
   endfunction

   function automatic int ofs_val(input logic [2:0] f);
      int v;
      v = int'(f);
      if (v >= 4) v = v - 8;
      return v & 255;
   endfunction

   task automatic check(input string tag, input int obs, input int exp);
      nassert++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_ref();
      for (int i = 0; i < MEMN; i++) mem[i] = w_nop();
      mem[0] = w_mul(0, 6);  mem[1] = w_add();
      mem[2] = w_mul(1, 1);  mem[3] = w_add();
      mem[4] = w_mul(2, 3);  mem[5] = w_add();
      mem[6] = w_mul(3, 5);  mem[7] = w_add();
      mem[8] = w_mul(4, 2);  mem[9] = w_add();
      mem[10] = w_end();
   endtask

   task automatic clear_stim();
      for (int i = 0; i < NC; i++) begin
         start_v[i] = 1'b0;
         stall_v[i] = 1'b0;
      end
   endtask

   function automatic void put(input int k, input int p, input bit b, input bit m,
                               input bit a, input bit d, input bit er);
      if (k < NC) begin
         e_pc[k] = p; e_busy[k] = b; e_mul[k] = m; e_add[k] = a;
         e_done[k] = d; e_err[k] = er; e_coef[k] = cur_coef; e_ofs[k] = cur_ofs;
      end
   endfunction

   // Walks the program one issue slot at a time and lays the results out per cycle.
   function automatic void build_trace();
      int c, k, p, op;
      bit m, a, fin;
      cur_coef = 0;
      cur_ofs  = 0;
      put(0, 0, 0, 0, 0, 0, 0);
      c = 0;
      while (c < NC - 1) begin
         if (!start_v[c]) begin
            put(c + 1, e_pc[c], 0, 0, 0, 0, e_err[c]);
            c++;
         end else begin
            k = c + 1; p = 0; m = 0; a = 0; fin = 0;
            while (!fin) begin
               put(k, p, 1, m, a, 0, 0);
               m = 0; a = 0;
               if (k >= NC - 1) begin
                  fin = 1; c = NC;
               end else if (stall_v[k]) begin
                  k++;
               end else begin
                  op = int'(mem[p][11:6]);
                  if (op == 3) begin
                     put(k + 1, p, 0, 0, 0, 1, 0);
                     put(k + 2, p, 0, 0, 0, 0, 0);
                     c = k + 2; fin = 1;
                  end else if (op > 3 && TRAP) begin
                     put(k + 1, p, 0, 0, 0, 0, 1);
                     put(k + 2, p, 0, 0, 0, 0, 1);
                     c = k + 2; fin = 1;
                  end else begin
                     if (op == 1) begin
                        m = 1;
                        cur_coef = int'(mem[p][5:3]);
                        cur_ofs  = ofs_val(mem[p][2:0]);
                     end
                     if (op == 2) a = 1;
                     if (p == MEMN - 1) begin
                        put(k + 1, p, 0, m, a, 0, 1);
                        put(k + 2, p, 0, 0, 0, 0, 1);
                        c = k + 2; fin = 1;
                     end else begin
                        p++; k++;
                     end
                  end
               end
            end
         end
      end
   endfunction

   task automatic run_scn(input string name, input bit do_reset);
      build_trace();
      if (do_reset) begin
         reset = 1'b1; start = 1'b0; stall = 1'b0;
         tick();
         reset = 1'b0;
      end
      for (int c = 0; c < NC; c++) begin
         o_pc[c] = int'(pc); o_busy[c] = int'(busy); o_mul[c] = int'(mul_en);
         o_add[c] = int'(add_en); o_coef[c] = int'(coef_sel);
         o_ofs[c] = int'($unsigned(offset_ext)); o_done[c] = int'(done); o_err[c] = int'(err);
         check($sformatf("%s_pc@%0d", name, c), o_pc[c], e_pc[c]);
         check($sformatf("%s_busy@%0d", name, c), o_busy[c], int'(e_busy[c]));
         check($sformatf("%s_mul@%0d", name, c), o_mul[c], int'(e_mul[c]));
         check($sformatf("%s_add@%0d", name, c), o_add[c], int'(e_add[c]));
         check($sformatf("%s_coef@%0d", name, c), o_coef[c], e_coef[c]);
         check($sformatf("%s_ofs@%0d", name, c), o_ofs[c], e_ofs[c]);
         check($sformatf("%s_done@%0d", name, c), o_done[c], int'(e_done[c]));
         check($sformatf("%s_err@%0d", name, c), o_err[c], int'(e_err[c]));
         check($sformatf("%s_excl@%0d", name, c), o_mul[c] & o_add[c], 0);
         start = start_v[c];
         stall = stall_v[c];
         tick();
      end
      start = 1'b0;
      stall = 1'b0;
   endtask

   task automatic check_ref_timing(input string name);
      check({name, "_busy1"}, o_busy[1], 1);
      check({name, "_pc1"}, o_pc[1], 0);
      check({name, "_mul2"}, o_mul[2], 1);
      check({name, "_coef2"}, o_coef[2], 0);
      check({name, "_ofs2"}, o_ofs[2], 8'hFE);
      check({name, "_add3"}, o_add[3], 1);
      check({name, "_mul10"}, o_mul[10], 1);
      check({name, "_coef10"}, o_coef[10], 4);
      check({name, "_ofs10"}, o_ofs[10], 8'h02);
      check({name, "_done11"}, o_done[11], 0);
      check({name, "_done12"}, o_done[12], 1);
      check({name, "_done13"}, o_done[13], 0);
      check({name, "_busy13"}, o_busy[13], 0);
      check({name, "_pc13"}, o_pc[13], 10);
   endtask

   initial begin
      int cnt, r;
      reset = 1'b1; start = 1'b0; stall = 1'b0;
      for (int i = 0; i < MEMN; i++) mem[i] = w_nop();
      tick();

      // 1: reference program
      load_ref(); clear_stim();
      start_v[0] = 1'b1;
      run_scn("t1", 1);
      check_ref_timing("t1");

      // 2: stall cycles 3-5
      load_ref(); clear_stim();
      start_v[0] = 1'b1;
      stall_v[3] = 1'b1; stall_v[4] = 1'b1; stall_v[5] = 1'b1;
      run_scn("t2", 1);
      for (int c = 4; c <= 6; c++) begin
         check($sformatf("t2_pc@%0d", c), o_pc[c], 2);
         check($sformatf("t2_en@%0d", c), o_mul[c] | o_add[c], 0);
      end
      check("t2_mul7", o_mul[7], 1);
      check("t2_coef7", o_coef[7], 1);
      check("t2_done12", o_done[12], 0);
      check("t2_done15", o_done[15], 1);

      // 3: reset mid-run, then a fresh run
      load_ref();
      reset = 1'b1; tick(); reset = 1'b0;
      start = 1'b1; tick(); start = 1'b0;
      repeat (5) tick();
      check("t3_pc6", int'(pc), 5);
      check("t3_coef6", int'(coef_sel), 2);
      reset = 1'b1; tick(); reset = 1'b0;
      check("t3_rst_pc", int'(pc), 0);
      check("t3_rst_busy", int'(busy), 0);
      check("t3_rst_en", int'(mul_en) + int'(add_en), 0);
      check("t3_rst_coef", int'(coef_sel), 0);
      check("t3_rst_ofs", int'($unsigned(offset_ext)), 0);
      check("t3_rst_flags", int'(done) + int'(err), 0);
      clear_stim();
      start_v[0] = 1'b1;
      run_scn("t3", 0);
      check_ref_timing("t3");

      // 4: no END, runs off the end of memory
      for (int i = 0; i < MEMN; i++) mem[i] = w_add();
      clear_stim();
      start_v[0] = 1'b1;
      run_scn("t4", 1);
      cnt = 0;
      for (int c = 0; c < NC; c++) cnt += o_add[c];
      check("t4_addcount", cnt, 64);
      cnt = 0;
      for (int c = 0; c < NC; c++) cnt += o_done[c];
      check("t4_donecount", cnt, 0);
      check("t4_add65", o_add[65], 1);
      check("t4_err64", o_err[64], 0);
      check("t4_err65", o_err[65], 1);
      check("t4_err66", o_err[66], 1);
      check("t4_busy66", o_busy[66], 0);
      check("t4_pc66", o_pc[66], 63);

      // 5: illegal word at address 1
      load_ref();
      mem[1] = 12'b111111_000_000;
      clear_stim();
      start_v[0] = 1'b1;
      run_scn("t5", 1);
      check("t5_add3", o_add[3], 0);
      if (TRAP) begin
         check("t5_err3", o_err[3], 1);
         check("t5_busy3", o_busy[3], 0);
         check("t5_done12", o_done[12], 0);
      end else begin
         check("t5_err13", o_err[13], 0);
         check("t5_done12", o_done[12], 1);
         check("t5_mul10", o_mul[10], 1);
      end

      // 6: start pulses during RUN and DONE
      load_ref(); clear_stim();
      start_v[0] = 1'b1; start_v[5] = 1'b1; start_v[12] = 1'b1;
      run_scn("t6", 1);
      check_ref_timing("t6");
      check("t6_busy14", o_busy[14], 0);

      // randomized programs, stalls and start pulses
      for (int it = 0; it < 6; it++) begin
         for (int i = 0; i < MEMN; i++) begin
            r = int'($urandom_range(0, 15));
            if (r < 4 || r == 15) mem[i] = w_nop();
            else if (r < 10) mem[i] = w_mul(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
            else if (r < 14) mem[i] = w_add();
            else mem[i] = {6'($urandom_range(4, 63)), 6'($urandom_range(0, 63))};
         end
         if (it % 3 != 2) mem[$urandom_range(2, 30)] = w_end();
         clear_stim();
         for (int c = 0; c < NC; c++) begin
            stall_v[c] = ($urandom_range(0, 3) == 0);
            start_v[c] = ($urandom_range(0, 9) == 0);
         end
         start_v[0] = 1'b1;
         run_scn($sformatf("rnd%0d", it), 1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
      $finish;
   end

endmodule
